// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in and received-byte / framing-status outputs of uart_rx.
interface uart_rx_if;
  logic       rx;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;
  modport master (input rx, output po_data, po_flag, frame_err);
  modport slave (output rx, input po_data, po_flag, frame_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling, data-valid and framing-error pulses.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting around mid-bit.
module uart_rx #(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000
) (
  input logic       sys_clk,
  input logic       sys_rst_n,
  uart_rx_if.master bus
);
  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int HALF = BAUD_CNT_MAX / 2 - 1;
  localparam int CW = BAUD_CNT_MAX > 1 ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          rx_s1, rx_s2, rx_s3;
  logic          armed;
  logic [1:0]    fill;
  logic          strobe, bit_v, flag_nxt, err_nxt;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] SMP_A = CW'(HALF - 1);
  localparam logic [CW-1:0] SMP_B = CW'(HALF);
  localparam logic [CW-1:0] SMP_C = CW'(HALF + 1);
  logic m0, m1;
  assign strobe = baud_cnt == SMP_C;
  assign bit_v  = (m0 & m1) | (m0 & rx_s2) | (m1 & rx_s2);
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      m0 <= 1'b1;
      m1 <= 1'b1;
    end else begin
      if (baud_cnt == SMP_A) m0 <= rx_s2;
      if (baud_cnt == SMP_B) m1 <= rx_s2;
    end
  end
`else
  localparam logic [CW-1:0] SMP = CW'(HALF);
  assign strobe = baud_cnt == SMP;
  assign bit_v  = rx_s2;
`endif
  always_comb begin
    state_nxt = state;
    flag_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE:  state_nxt = (armed && rx_s3 && !rx_s2) ? START : IDLE;
      START: state_nxt = strobe ? (bit_v ? IDLE : DATA) : START;
      DATA:  state_nxt = (strobe && bit_cnt == 3'd7) ? STOP : DATA;
      STOP: begin
        state_nxt = strobe ? IDLE : STOP;
        flag_nxt  = strobe && bit_v;
        err_nxt   = strobe && !bit_v;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // fill keeps armed off until rx_s2 carries a real line sample rather than its reset value
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_s3         <= 1'b1;
      armed         <= 1'b0;
      fill          <= '0;
      bus.po_data   <= '0;
      bus.po_flag   <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      rx_s1         <= bus.rx;
      rx_s2         <= rx_s1;
      rx_s3         <= rx_s2;
      fill          <= {fill[0], 1'b1};
      armed         <= armed | (&fill & rx_s2);
      state         <= state_nxt;
      baud_cnt      <= (state == IDLE || baud_cnt == CNT_LAST) ? '0 : baud_cnt + 1'b1;
      bus.po_flag   <= flag_nxt;
      bus.frame_err <= err_nxt;
      if (flag_nxt) bus.po_data <= shift;
      if (state == START && strobe) bit_cnt <= '0;
      if (state == DATA && strobe) begin
        shift   <= {bit_v, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
endmodule
